// File: rtl/smbus_echo_mc.sv
// ---------------------------------------------------------------------------
// smbus_echo_mc
//
// Multi-channel SMBus event relay/echo block feeding the LTPI frame builder.
// Each channel detects new local events and changes on the remote event
// stream. It queues the local events, plus an echo acknowledgement of each
// remote event when echo is enabled, in a QDEPTH-deep FIFO. A presenter FSM
// then holds every queued event on the frame-builder side for
// frm_tc_cnt+1 clock ticks.
//
// There are no valid/ready handshakes here. Events are level codes. A new
// local event is a transition from idle to non-idle. A remote event is any
// change of the remote code. Nothing stalls upstream: a write that finds its
// queue full is dropped and recorded in the sticky ovf flag.
//
// Event encoding (4-bit smbus_event_t values as used by the LTPI encoders):
//   0 idle        1 start        2 stop        3 data_0       4 data_1
//   5 start_rcv   6 stop_rcv     7 bit_rcv     8 start_echo   9 stop_echo
//  10 data_0_echo 11 data_1_echo 12 data_rcv_echo
//
// Ports (channel c occupies bits [4c+3:4c] of every event bus):
//   clk              system clock
//   reset            asynchronous, active-high reset
//   frm_tc_cnt       hold length minus one, latched at each pop
//   echo_en          per-channel echo enable
//   ovf_clr          per-channel overflow clear pulse
//   i2c_event_i      remote event in
//   i2c_event_i_echo one-cycle registered copy of a changed remote event
//   i2c_event_o      local event in
//   i2c_event_o_echo event presented to the frame builder
//   q_level          per-channel queue occupancy ($clog2(QDEPTH)+1 bits each)
//   ovf              sticky per-channel queue-overflow flag
//
// Each channel's FSM state is visible as g_ch[c].state for debug and bind.
// ---------------------------------------------------------------------------
module smbus_echo_mc #(
    parameter int NUM_CH = 2,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 10
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CNT_W-1:0]                      frm_tc_cnt,
    input  logic [NUM_CH-1:0]                     echo_en,
    input  logic [NUM_CH-1:0]                     ovf_clr,
    input  logic [4*NUM_CH-1:0]                   i2c_event_i,
    output logic [4*NUM_CH-1:0]                   i2c_event_i_echo,
    input  logic [4*NUM_CH-1:0]                   i2c_event_o,
    output logic [4*NUM_CH-1:0]                   i2c_event_o_echo,
    output logic [($clog2(QDEPTH)+1)*NUM_CH-1:0]  q_level,
    output logic [NUM_CH-1:0]                     ovf
);

    localparam int PW = $clog2(QDEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] Q_FULL = LW'(QDEPTH);

    localparam logic [3:0] EV_IDLE          = 4'd0;
    localparam logic [3:0] EV_START         = 4'd1;
    localparam logic [3:0] EV_STOP          = 4'd2;
    localparam logic [3:0] EV_DATA_0        = 4'd3;
    localparam logic [3:0] EV_DATA_1        = 4'd4;
    localparam logic [3:0] EV_START_RCV     = 4'd5;
    localparam logic [3:0] EV_STOP_RCV      = 4'd6;
    localparam logic [3:0] EV_BIT_RCV       = 4'd7;
    localparam logic [3:0] EV_START_ECHO    = 4'd8;
    localparam logic [3:0] EV_STOP_ECHO     = 4'd9;
    localparam logic [3:0] EV_DATA_0_ECHO   = 4'd10;
    localparam logic [3:0] EV_DATA_1_ECHO   = 4'd11;
    localparam logic [3:0] EV_DATA_RCV_ECHO = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

        logic [3:0]       ev_i;
        logic [3:0]       ev_o;
        logic [3:0]       i_ff;
        logic [3:0]       o_ff;
        logic             i_chg;
        logic             o_new;
        logic             i_listed;
        logic             echo_map;
        logic [3:0]       echo_code;
        logic             echo_req;
        logic [3:0]       i_echo_q;

        logic [3:0]       mem [QDEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    wr2_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [LW-1:0]    level;
        logic             wr1;
        logic             wr2;
        logic             drop;
        logic             ovf_q;

        state_t           state;
        state_t           state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic [CNT_W-1:0] hold_max;
        logic [CNT_W-1:0] hold_max_nx;
        logic [3:0]       out_q;
        logic [3:0]       out_nx;
        logic             pop;

        assign ev_i  = i2c_event_i[4*c +: 4];
        assign ev_o  = i2c_event_o[4*c +: 4];
        assign i_chg = (ev_i != i_ff);
        assign o_new = (ev_o != EV_IDLE) && (o_ff == EV_IDLE);

        // Remote code classification. A listed code is always copied to
        // i2c_event_i_echo. start_rcv is listed but has no echo. stop_rcv
        // echoes as an idle entry, which still occupies a presentation slot.
        always_comb begin
            i_listed  = 1'b1;
            echo_map  = 1'b1;
            echo_code = EV_IDLE;
            case (ev_i)
                EV_START:     echo_code = EV_START_ECHO;
                EV_DATA_0:    echo_code = EV_DATA_0_ECHO;
                EV_DATA_1:    echo_code = EV_DATA_1_ECHO;
                EV_BIT_RCV:   echo_code = EV_DATA_RCV_ECHO;
                EV_STOP:      echo_code = EV_STOP_ECHO;
                EV_STOP_RCV:  echo_code = EV_IDLE;
                EV_START_RCV: echo_map  = 1'b0;
                default: begin
                    i_listed = 1'b0;
                    echo_map = 1'b0;
                end
            endcase
        end

        assign echo_req = i_chg && echo_map;

        // Up to two in-order writes per cycle: the local event first, then the
        // echo. Fullness is judged on the occupancy at the start of the cycle
        // plus any earlier write in the same cycle. A pop in the same cycle
        // does not make room for a write.
        assign wr1     = o_new && (level != Q_FULL);
        assign wr2     = echo_req && echo_en[c] && ((level + LW'(wr1)) != Q_FULL);
        assign wr2_ptr = wr_ptr + PW'(wr1);
        assign drop    = (o_new && !wr1) || (echo_req && echo_en[c] && !wr2);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < QDEPTH; k++) begin
                    mem[k] <= EV_IDLE;
                end
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                ovf_q    <= 1'b0;
                i_ff     <= EV_IDLE;
                o_ff     <= EV_IDLE;
                i_echo_q <= EV_IDLE;
            end else begin
                if (wr1) begin
                    mem[wr_ptr] <= ev_o;
                end
                if (wr2) begin
                    mem[wr2_ptr] <= echo_code;
                end
                wr_ptr   <= wr_ptr + PW'(wr1) + PW'(wr2);
                rd_ptr   <= rd_ptr + PW'(pop);
                level    <= level + LW'(wr1) + LW'(wr2) - LW'(pop);
                // A drop in the same cycle as a clear keeps the flag set.
                if (drop) begin
                    ovf_q <= 1'b1;
                end else if (ovf_clr[c]) begin
                    ovf_q <= 1'b0;
                end
                i_ff     <= ev_i;
                o_ff     <= ev_o;
                i_echo_q <= (i_chg && i_listed) ? ev_i : EV_IDLE;
            end
        end

        // Presenter FSM. While in ST_HOLD, out_q is the held event itself, so
        // it decides whether a stop_rcv gap must follow.
        always_comb begin
            state_nx    = state;
            cnt_nx      = cnt;
            hold_max_nx = hold_max;
            out_nx      = out_q;
            pop         = 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (level != '0) begin
                        pop         = 1'b1;
                        out_nx      = mem[rd_ptr];
                        hold_max_nx = frm_tc_cnt;
                        cnt_nx      = '0;
                        state_nx    = ST_HOLD;
                    end else begin
                        out_nx = EV_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cnt == hold_max) begin
                        out_nx   = EV_IDLE;
                        cnt_nx   = '0;
                        state_nx = (out_q == EV_STOP_RCV) ? ST_GAP : ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // A full idle frame, hold_max+1 ticks long.
                    if (cnt == hold_max) begin
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    out_nx   = EV_IDLE;
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                hold_max <= '0;
                out_q    <= EV_IDLE;
            end else begin
                state    <= state_nx;
                cnt      <= cnt_nx;
                hold_max <= hold_max_nx;
                out_q    <= out_nx;
            end
        end

        assign i2c_event_i_echo[4*c +: 4]  = i_echo_q;
        assign i2c_event_o_echo[4*c +: 4]  = out_q;
        assign q_level[LW*c +: LW]         = level;
        assign ovf[c]                      = ovf_q;

    end : g_ch

endmodule

// File: doc/smbus_echo_mc.md
# smbus_echo_mc

Multi-channel, parametrised SMBus event relay/echo block for the LTPI management interface. It sits between the per-channel SMBus event encoders/decoders and the LTPI frame builder. It relays local SMBus events and, when enabled, echo acknowledgements of remote events. Unlike the single-channel predecessor, each channel has a QDEPTH-deep event queue instead of a single "next" slot, so no event is lost while a frame is being held. The frame hold length is a runtime input rather than a fixed per-speed table.

## Interface
Parameters:
- NUM_CH, 2, number of independent SMBus channels (1..8)
- QDEPTH, 4, per-channel event queue depth (power of 2, 2..16)
- CNT_W, 10, width of frame-tick count

Ports (event fields are 4-bit smbus_event_t from ltpi_pkg; channel c occupies bits [4c+3:4c]):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frm_tc_cnt  in  CNT_W  hold length minus one, in clk ticks, per presented event (computed upstream from link_speed/DDR)
- echo_en  in  NUM_CH  per-channel echo enable
- ovf_clr  in  NUM_CH  per-channel overflow flag clear, single-cycle pulse
- i2c_event_i  in  4*NUM_CH  event received from remote side
- i2c_event_i_echo  out  4*NUM_CH  registered one-cycle copy of a changed remote event, otherwise idle
- i2c_event_o  in  4*NUM_CH  local event to transmit
- i2c_event_o_echo  out  4*NUM_CH  event presented to the frame builder
- q_level  out  ($clog2(QDEPTH)+1)*NUM_CH  per-channel queue occupancy
- ovf  out  NUM_CH  sticky per-channel queue-overflow flag

## Operation
Channels are fully independent; everything below applies per channel.
- Remote change detect: i_chg = (i2c_event_i != i_ff), where i_ff is i2c_event_i registered.
- Remote echo mapping on i_chg:
  - start→start_echo, data_0→data_0_echo, data_1→data_1_echo, bit_rcv→data_rcv_echo, stop→stop_echo, stop_rcv→idle. Each of these produces an echo request.
  - start_rcv and all other codes produce no echo request.
- i2c_event_i_echo: on i_chg with a listed code (including start_rcv), it takes i2c_event_i for one cycle; otherwise idle.
- Local detect: o_new = (i2c_event_o != idle) && (o_ff == idle), where o_ff is i2c_event_o registered.
- Queue push, with up to 2 writes per cycle:
  - the o_new event is written first;
  - then the echo request, only if echo_en=1.
  - Writes are in order. Any write that finds the queue full is dropped and sets ovf.
  - ovf_clr clears ovf. If a set and a clear occur in the same cycle, set wins.
- Presenter FSM:
  - ST_IDLE:
    - If the queue is non-empty: pop the head, i2c_event_o_echo<=head, latch hold_cnt_max<=frm_tc_cnt, cnt<=0, go to ST_HOLD.
    - Otherwise i2c_event_o_echo<=idle.
  - ST_HOLD:
    - If cnt==hold_cnt_max: i2c_event_o_echo<=idle. Go to ST_GAP if the held event was stop_rcv, else go to ST_IDLE.
    - Otherwise cnt<=cnt+1.
  - ST_GAP: hold idle for hold_cnt_max+1 cycles using the same counter, then go to ST_IDLE. This guarantees a full idle frame after stop_rcv.
- A pop and a push in the same cycle are both honoured; a pop from an empty queue is impossible.
- Deasserting echo_en only stops new echo pushes. Queued echoes still drain.
- A frm_tc_cnt change takes effect at the next pop only.

## Timing
- Reset values: i2c_event_i_echo=idle, i2c_event_o_echo=idle, q_level=0, ovf=0, FSM=ST_IDLE, cnt=0, queues empty, i_ff/o_ff=idle. All registers are on the async reset.
- Latency, local event: input sampled at edge k-1 while idle, then non-idle before edge k. The push happens at edge k and the pop at edge k+1. i2c_event_o_echo is valid after edge k+1 when the FSM was idle.
- Latency, echo: same 2-edge path. i2c_event_i_echo is valid after edge k.
- An event is non-idle on i2c_event_o_echo for exactly frm_tc_cnt+1 cycles.
- Back-to-back events are always separated by at least 1 idle cycle (the ST_IDLE cycle).
- q_level is updated at the push/pop edge; a simultaneous push+pop leaves it unchanged.
- Reset mid-hold: outputs go idle immediately (asynchronous), queued events are discarded, and no ovf is set.

## Test plan
- NUM_CH=2, frm_tc_cnt=5, ch0 i2c_event_o idle→start at edge 10 → ch0 i2c_event_o_echo=start for cycles 12..17, idle at 18; ch1 stays idle.
- echo_en=1, i2c_event_i idle→data_1 → i2c_event_i_echo=data_1 for 1 cycle; i2c_event_o_echo=data_1_echo for frm_tc_cnt+1 cycles.
- Simultaneous local stop and remote data_0 with echo_en=1 → stop is presented first, then a 1-cycle gap, then data_0_echo; q_level peaks at 2.
- QDEPTH=4, 6 local events injected during one long hold (frm_tc_cnt=100) → q_level=4 and ovf=1; exactly 4 events are presented in order. ovf_clr drops ovf to 0.
- Local stop_rcv presented, then an event queued → the queued event appears only after 2×(frm_tc_cnt+1) cycles plus 1.
- Assert reset during a hold with q_level=3 → outputs idle and q_level=0 the same cycle. After release, a new event is presented with the normal 2-cycle latency.
